// File: rtl/conv_scheduler_pkg.sv
// Shared types and constants for the convolution layer frame sequencer.
package conv_scheduler_pkg;

  localparam int unsigned PIXEL_WIDTH_OUT     = 8;
  localparam int unsigned KERNEL_NUM          = 24;
  localparam int unsigned KERNEL_COUNTER_BITS = $clog2(KERNEL_NUM);
  localparam int unsigned BITS_Q4_6           = 10;
  localparam int unsigned KWAIT_TIMEOUT       = 4;

  // One 3x3 kernel of signed/unsigned bytes as delivered by the kernel ROM.
  typedef logic [2:0][2:0][7:0] matrix_3x3_8bits;

  // One Q4.6 result per output channel.
  typedef logic [KERNEL_NUM-1:0][BITS_Q4_6-1:0] vector_8_Q4_6;

  typedef enum logic [2:0] {IDLE, LOAD, KWAIT, STREAM, DONE} sched_state_e;

endpackage

// File: rtl/conv_result_serializer.sv
// Holds one KERNEL_NUM-wide result and emits it one channel per valid/ready transfer.
module conv_result_serializer
  import conv_scheduler_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         capture,
  input  vector_8_Q4_6                 result,
  input  logic                         ready,
  output logic                         valid,
  output logic [BITS_Q4_6-1:0]         data,
  output logic [KERNEL_COUNTER_BITS:0] ch,
  output logic                         last_ch_c,
  output logic                         full_nxt_c,
  output logic                         drop_c
);

  localparam int unsigned CH_W = KERNEL_COUNTER_BITS + 1;

  vector_8_Q4_6 held;
  logic         pop;
  logic         last_pop;
  logic         load;

  assign pop        = valid && ready;
  assign last_ch_c  = (ch == CH_W'(KERNEL_NUM - 1));
  assign last_pop   = pop && last_ch_c;
  // A capture is taken when the buffer is empty or is emptying this cycle.
  assign load       = capture && (!valid || last_pop);
  assign drop_c     = capture && !load;
  assign full_nxt_c = load || (valid && !last_pop);
  assign data       = held[ch[KERNEL_COUNTER_BITS-1:0]];

  // Buffer fill, channel stepping and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held  <= '0;
      valid <= 1'b0;
      ch    <= '0;
    end else if (load) begin
      held  <= result;
      valid <= 1'b1;
      ch    <= '0;
    end else if (pop) begin
      valid <= !last_pop;
      ch    <= last_pop ? '0 : ch + CH_W'(1);
    end
  end

endmodule

// File: rtl/conv_scheduler.sv
// Frame sequencer: kernel burst load, pixel streaming and result serialisation.
module conv_scheduler
  import conv_scheduler_pkg::*;
#(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                         clk_i,
  input  logic                         nreset_i,
  input  logic                         start_i,
  output logic [ADDR_W-1:0]            kernel_addr_o,
  input  matrix_3x3_8bits              kernel_data_i,
  output matrix_3x3_8bits              kernel_o,
  output logic                         kernel_valid_o,
  input  logic                         kernels_ready_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [PIXEL_WIDTH_OUT-1:0]   in_px_i,
  output logic                         px_rdy_o,
  output logic [PIXEL_WIDTH_OUT-1:0]   px_o,
  input  logic                         conv_px_rdy_i,
  input  vector_8_Q4_6                 conv_result_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [BITS_Q4_6-1:0]         out_data_o,
  output logic [KERNEL_COUNTER_BITS:0] out_ch_o,
  output logic                         out_last_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overrun_o
);

  localparam int unsigned NPX   = IMG_W * IMG_H;
  localparam int unsigned NRES  = (IMG_W - 2) * (IMG_H - 2);
  localparam int unsigned PX_W  = $clog2(NPX) + 1;
  localparam int unsigned RES_W = $clog2(NRES) + 1;
  localparam int unsigned LD_W  = KERNEL_COUNTER_BITS + 1;
  localparam int unsigned TO_W  = $clog2(KWAIT_TIMEOUT);

  sched_state_e     state;
  logic [PX_W-1:0]  px_cnt;
  logic [PX_W-1:0]  px_nxt;
  logic [RES_W-1:0] res_cnt;
  logic [RES_W-1:0] res_nxt;
  logic [LD_W-1:0]  ld_cnt;
  logic [TO_W-1:0]  wait_cnt;
  logic             streaming;
  logic             capture;
  logic             last_ch;
  logic             full_nxt;
  logic             drop;
  logic             frame_end_c;

  assign kernel_o   = kernel_data_i;
  assign streaming  = (state == STREAM);
  assign in_ready_o = streaming && !out_valid_o && (px_cnt < PX_W'(NPX));
  assign px_rdy_o   = in_valid_i && in_ready_o;
  assign px_o       = px_rdy_o ? in_px_i : '0;
  assign capture    = streaming && conv_px_rdy_i;
  assign px_nxt     = px_cnt + PX_W'(px_rdy_o);
  assign res_nxt    = (capture && (res_cnt < RES_W'(NRES))) ? res_cnt + RES_W'(1) : res_cnt;
  // Frame ends on the cycle whose updates complete all counts and drain the buffer.
  assign frame_end_c = streaming && (px_nxt == PX_W'(NPX)) && (res_nxt == RES_W'(NRES)) && !full_nxt;
  assign out_last_o  = out_valid_o && last_ch && (res_cnt == RES_W'(NRES));

  conv_result_serializer u_ser (
    .clk        (clk_i),
    .rst_n      (nreset_i),
    .capture    (capture),
    .result     (conv_result_i),
    .ready      (out_ready_i),
    .valid      (out_valid_o),
    .data       (out_data_o),
    .ch         (out_ch_o),
    .last_ch_c  (last_ch),
    .full_nxt_c (full_nxt),
    .drop_c     (drop)
  );

  // Frame FSM with its counters and registered control outputs.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state          <= IDLE;
      px_cnt         <= '0;
      res_cnt        <= '0;
      ld_cnt         <= '0;
      wait_cnt       <= '0;
      kernel_addr_o  <= '0;
      kernel_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      kernel_valid_o <= 1'b0;
      done_o         <= 1'b0;
      if (drop) overrun_o <= 1'b1;
      if (streaming) begin
        px_cnt  <= px_nxt;
        res_cnt <= res_nxt;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            state         <= LOAD;
            busy_o        <= 1'b1;
            overrun_o     <= 1'b0;
            px_cnt        <= '0;
            res_cnt       <= '0;
            ld_cnt        <= '0;
            kernel_addr_o <= '0;
          end
        end
        LOAD: begin
          if (ld_cnt < LD_W'(KERNEL_NUM)) begin
            kernel_valid_o <= 1'b1;
            ld_cnt         <= ld_cnt + LD_W'(1);
            if (ld_cnt < LD_W'(KERNEL_NUM - 1)) kernel_addr_o <= kernel_addr_o + ADDR_W'(1);
          end else begin
            state         <= KWAIT;
            wait_cnt      <= '0;
            kernel_addr_o <= '0;
          end
        end
        KWAIT: begin
          if (kernels_ready_i) begin
            state <= STREAM;
          end else if (wait_cnt == TO_W'(KWAIT_TIMEOUT - 1)) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            overrun_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        STREAM: begin
          if (frame_end_c) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler: per-frame scenario table plus a transaction-level reference model.
module tb_conv_scheduler;
  import conv_scheduler_pkg::*;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int NPX  = IMG_W * IMG_H;
  localparam int NRES = (IMG_W - 2) * (IMG_H - 2);

  logic                         clk_i = 1'b0;
  logic                         nreset_i;
  logic                         start_i;
  logic [ADDR_W-1:0]            kernel_addr_o;
  matrix_3x3_8bits              kernel_data_i;
  matrix_3x3_8bits              kernel_o;
  logic                         kernel_valid_o;
  logic                         kernels_ready_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [PIXEL_WIDTH_OUT-1:0]   in_px_i;
  logic                         px_rdy_o;
  logic [PIXEL_WIDTH_OUT-1:0]   px_o;
  logic                         conv_px_rdy_i;
  vector_8_Q4_6                 conv_result_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [BITS_Q4_6-1:0]         out_data_o;
  logic [KERNEL_COUNTER_BITS:0] out_ch_o;
  logic                         out_last_o;
  logic                         busy_o;
  logic                         done_o;
  logic                         overrun_o;

  conv_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .start_i(start_i),
    .kernel_addr_o(kernel_addr_o), .kernel_data_i(kernel_data_i),
    .kernel_o(kernel_o), .kernel_valid_o(kernel_valid_o), .kernels_ready_i(kernels_ready_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_px_i(in_px_i),
    .px_rdy_o(px_rdy_o), .px_o(px_o), .conv_px_rdy_i(conv_px_rdy_i),
    .conv_result_i(conv_result_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_ch_o(out_ch_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Kernel ROM: word k has every byte equal to k, one cycle read latency.
  always @(posedge clk_i) kernel_data_i <= {9{8'(kernel_addr_o)}};

  typedef struct {
    int kdelay;     // cycles in KWAIT before kernels_ready_i rises (>=4: never)
    int pix_pct;
    int ord_pct;
    int res_pct;
    bit force_ovr;  // push one extra result into a full buffer
    bit noise;      // random start_i pulses while busy
    bit exp_done;
    bit exp_ovr;
    int exp_xfers;
  } vec_t;

  typedef struct {
    int                   ch;
    logic [BITS_Q4_6-1:0] val;
  } item_t;

  int    vecs = 0;
  int    errs = 0;
  int    cyc = 0;
  int    s, stream_start, done_at, px_acc, res, issued, xfers, lasts, dones;
  bit    tmo, exp_ovr, forced;
  vec_t  cur;
  vec_t  rows[6];
  item_t q[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit exp_busy();
    return (cyc >= s + 1) && !(tmo && cyc >= s + 30) && !(done_at >= 0 && cyc > done_at);
  endfunction

  function automatic bit in_stream();
    return !tmo && (cyc >= stream_start) && (done_at < 0);
  endfunction

  // One clock of stimulus, checking and reference-model update.
  task automatic step();
    bit    st = in_stream();
    bit    ir = st && (q.size() == 0) && (px_acc < NPX);
    bit    kv = (cyc >= s + 2) && (cyc <= s + 25);
    bit    ev = (q.size() != 0);
    bit    el = 1'b0;
    item_t it;

    start_i         = (cyc == s) || (cur.noise && cyc > s && exp_busy() && $urandom_range(0, 99) < 20);
    kernels_ready_i = exp_busy() && (cyc >= s + 26 + cur.kdelay);
    in_valid_i      = $urandom_range(0, 99) < cur.pix_pct;
    in_px_i         = 8'($urandom);
    out_ready_i     = $urandom_range(0, 99) < cur.ord_pct;
    for (int k = 0; k < KERNEL_NUM; k++) conv_result_i[k] = 10'($urandom);
    conv_px_rdy_i   = 1'b0;
    if (st && issued < NRES) begin
      if (cur.force_ovr && !forced && q.size() == KERNEL_NUM) begin
        out_ready_i   = 1'b0;
        conv_px_rdy_i = 1'b1;
        forced        = 1'b1;
      end else if ((q.size() == 0 || (q.size() == 1 && out_ready_i)) &&
                   $urandom_range(0, 99) < cur.res_pct) begin
        conv_px_rdy_i = 1'b1;
      end
      if (conv_px_rdy_i) issued++;
    end

    #1;
    chk("busy", busy_o, exp_busy());
    chk("done", done_o, cyc == done_at);
    chk("overrun", overrun_o, exp_ovr);
    chk("kernel_valid", kernel_valid_o, kv);
    if (kv) chk("kernel_word", kernel_o, {9{8'(cyc - s - 2)}});
    chk("in_ready", in_ready_o, ir);
    chk("px_rdy", px_rdy_o, in_valid_i && ir);
    if (in_valid_i && ir) chk("px_data", px_o, in_px_i);
    chk("out_valid", out_valid_o, ev);
    if (ev) begin
      el = (q[0].ch == KERNEL_NUM - 1) && (res == NRES);
      chk("out_data", out_data_o, q[0].val);
      chk("out_ch", out_ch_o, q[0].ch);
    end
    chk("out_last", out_last_o, el);
    if (done_o) dones++;

    if (cyc == s) exp_ovr = 1'b0;
    if (tmo && cyc == s + 29) exp_ovr = 1'b1;
    if (in_valid_i && ir) px_acc++;
    if (ev && out_ready_i) begin
      xfers++;
      if (el) lasts++;
      void'(q.pop_front());
    end
    if (st && conv_px_rdy_i) begin
      if (q.size() == 0) begin
        for (int k = 0; k < KERNEL_NUM; k++) begin
          it.ch  = k;
          it.val = conv_result_i[k];
          q.push_back(it);
        end
      end else begin
        exp_ovr = 1'b1;
      end
      if (res < NRES) res++;
    end
    if (st && px_acc == NPX && res == NRES && q.size() == 0) done_at = cyc + 1;

    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  // Runs one frame from start_i; stops early once abort_px pixels were accepted.
  task automatic run_frame(input vec_t v, input int abort_px);
    bit ended = 1'b0;
    cur          = v;
    s            = cyc;
    tmo          = (v.kdelay >= int'(KWAIT_TIMEOUT));
    stream_start = tmo ? (1 << 30) : s + 27 + v.kdelay;
    done_at      = -1;
    px_acc = 0; res = 0; issued = 0; xfers = 0; lasts = 0; dones = 0;
    forced = 1'b0;
    q.delete();
    for (int n = 0; n < 4000; n++) begin
      if ((done_at >= 0 && cyc > done_at + 1) || (tmo && cyc > s + 31)) begin
        ended = 1'b1;
        break;
      end
      if (abort_px > 0 && px_acc >= abort_px) return;
      step();
    end
    chk("frame_end", ended, 1'b1);
    chk("done_count", dones, v.exp_done);
    chk("final_overrun", overrun_o, v.exp_ovr);
    chk("transfers", xfers, v.exp_xfers);
    chk("last_count", lasts, v.exp_done);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    //           kd  pix ord res ovr noi done ovr xfers
    rows[0] = '{0, 100, 100, 100, 1'b0, 1'b0, 1'b1, 1'b0, NRES * KERNEL_NUM};
    rows[1] = '{2,  60,  30,  50, 1'b0, 1'b0, 1'b1, 1'b0, NRES * KERNEL_NUM};
    rows[2] = '{1,  70,  50,  70, 1'b1, 1'b0, 1'b1, 1'b1, (NRES - 1) * KERNEL_NUM};
    rows[3] = '{3,  50,  80,  40, 1'b0, 1'b1, 1'b1, 1'b0, NRES * KERNEL_NUM};
    rows[4] = '{9,  80,  80,  80, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    rows[5] = '{0,  90,  90,  90, 1'b0, 1'b1, 1'b1, 1'b0, NRES * KERNEL_NUM};

    nreset_i = 1'b0; start_i = 1'b0; kernels_ready_i = 1'b0; in_valid_i = 1'b0;
    in_px_i = '0; conv_px_rdy_i = 1'b0; conv_result_i = '0; out_ready_i = 1'b0;
    exp_ovr = 1'b0; s = 0; done_at = -1; tmo = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_overrun", overrun_o, 1'b0);
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_kernel_valid", kernel_valid_o, 1'b0);
    chk("rst_kernel_addr", kernel_addr_o, 0);
    chk("rst_px_rdy", px_rdy_o, 1'b0);
    chk("rst_out_last", out_last_o, 1'b0);
    chk("rst_out_ch", out_ch_o, 0);
    chk("rst_out_data", out_data_o, 0);
    nreset_i = 1'b1;
    @(negedge clk_i);

    run_frame(rows[0], 0);

    // Reset pulse after 10 accepted pixels, then a fresh frame must reload from address 0.
    run_frame(rows[0], 10);
    nreset_i = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_in_ready", in_ready_o, 1'b0);
    chk("midrst_out_valid", out_valid_o, 1'b0);
    chk("midrst_kernel_addr", kernel_addr_o, 0);
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    nreset_i = 1'b1;
    exp_ovr  = 1'b0;
    @(negedge clk_i);
    cyc++;

    for (int r = 0; r < 6; r++) run_frame(rows[r], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
